// File: rtl/button_pkg.sv
// Shared types and defaults for the button conditioning stage.
// Optional long-press detection is compiled in with BUTTON_DEBOUNCER_LONG_PRESS_EN.
package button_pkg;

  // Per-channel debounce state. The encoding is fixed so that debug tooling
  // can decode state_dbg directly.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } deb_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_CNT_W           = 8;
  localparam int DEFAULT_LONG_CYCLES     = 1000000;

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-FF synchroniser, debounce FSM, edge pulses,
// press counter and (with BUTTON_DEBOUNCER_LONG_PRESS_EN) a long-press pulse.
module debounce_chan
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  ,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw,
  input  logic             clr,
  output logic             db,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] count,
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  output logic             long_press,
`endif
  output logic [1:0]       state_dbg
);

  localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync;
  logic            s;
  deb_state_e      state;
  logic [DB_W-1:0] cnt;
  logic            accept_rise;

  assign s           = sync[1];
  assign state_dbg   = state;
  // The rising accept is needed by the press counter in the same edge that
  // raises the registered rise pulse.
  assign accept_rise = (state == CHECK_HIGH) && s && (cnt == CNT_LAST);

  // Two-flop synchroniser for the asynchronous pad.
  always_ff @(posedge clk) begin
    if (reset) sync <= 2'b00;
    else       sync <= {sync[0], raw};
  end

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive agreeing samples; any reversal drops back to the stable state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STABLE_LOW;
      cnt   <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (s) begin
            state <= CHECK_HIGH;
            cnt   <= DB_W'(1);
          end
        end
        CHECK_HIGH: begin
          if (!s) begin
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
            db    <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + DB_W'(1);
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            state <= CHECK_LOW;
            cnt   <= DB_W'(1);
          end
        end
        CHECK_LOW: begin
          if (s) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            db    <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + DB_W'(1);
          end
        end
        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Press counter: a clear coinciding with a new press keeps that press.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (accept_rise) begin
      count <= clr ? CNT_W'(1) : count + CNT_W'(1);
    end else if (clr) begin
      count <= '0;
    end
  end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam int              HOLD_W    = $clog2(LONG_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold;
  logic              fired;

  // Long-press timer: counts undisturbed high samples after a rise and fires
  // once per press; a glitch back through CHECK_LOW restarts the timing but
  // cannot produce a second pulse for the same press.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= '0;
      fired      <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (accept_rise) begin
        hold  <= '0;
        fired <= 1'b0;
      end else if (state == STABLE_HIGH && s) begin
        if (!fired) begin
          if (hold == HOLD_LAST) begin
            long_press <= 1'b1;
            fired      <= 1'b1;
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end
      end else begin
        hold <= '0;
      end
    end
  end
`endif

endmodule

// File: rtl/button_debouncer.sv
// Button conditioning stage: N_BUTTONS independent debounce channels with
// flattened press counters. Long-press pulses are added when
// BUTTON_DEBOUNCER_LONG_PRESS_EN is defined. state_dbg exposes each channel's
// FSM state (channel i at bits [2*i +: 2]).
module button_debouncer
  import button_pkg::*;
#(
  parameter int N_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  ,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_BUTTONS-1:0]       btn_raw,
  output logic [N_BUTTONS-1:0]       btn_db,
  output logic [N_BUTTONS-1:0]       btn_rise,
  output logic [N_BUTTONS-1:0]       btn_fall,
  input  logic [N_BUTTONS-1:0]       press_clr,
  output logic [N_BUTTONS*CNT_W-1:0] press_count,
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  output logic [N_BUTTONS-1:0]       btn_long,
`endif
  output logic [2*N_BUTTONS-1:0]     state_dbg
);

  // One self-contained channel per button.
  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
      ,
      .LONG_CYCLES     (LONG_CYCLES)
`endif
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .raw        (btn_raw[i]),
      .clr        (press_clr[i]),
      .db         (btn_db[i]),
      .rise       (btn_rise[i]),
      .fall       (btn_fall[i]),
      .count      (press_count[i*CNT_W +: CNT_W]),
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
      .long_press (btn_long[i]),
`endif
      .state_dbg  (state_dbg[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer (DEBOUNCE_CYCLES=4, CNT_W=4, LONG_CYCLES=10).
// A behavioural model predicts every output each cycle; directed phases pin
// the model with literal expectations, then a randomized phase runs.
// Long-press checks are compiled with BUTTON_DEBOUNCER_LONG_PRESS_EN.
module tb_button_debouncer;

  localparam int DEB  = 4;
  localparam int CW   = 4;
  localparam int LONG = 10;

  logic       clk;
  logic       reset;
  logic [1:0] btn_raw;
  logic [1:0] btn_db;
  logic [1:0] btn_rise;
  logic [1:0] btn_fall;
  logic [1:0] press_clr;
  logic [7:0] press_count;
  logic [3:0] state_dbg;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  logic [1:0] btn_long;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Expected vector: {long[1:0], count1, count0, fall[1:0], rise[1:0], db[1:0]}
  logic [15:0] exp_q[$];

  button_debouncer #(
    .N_BUTTONS       (2),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CW)
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    ,
    .LONG_CYCLES     (LONG)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_db      (btn_db),
    .btn_rise    (btn_rise),
    .btn_fall    (btn_fall),
    .press_clr   (press_clr),
    .press_count (press_count),
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    .btn_long    (btn_long),
`endif
    .state_dbg   (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Rule: the debounced level flips once DEB consecutive synchronised samples
  // (raw delayed by two edges) disagree with it.
  logic [1:0] pipe_m [2];
  logic       db_m   [2];
  int         run_m  [2];
  logic [3:0] cnt_m  [2];
  int         quiet_m[2];
  bit         fired_m[2];

  always @(posedge clk) begin
    logic [1:0] r, f, lg;
    logic       s;
    int         prev_run;
    r = 2'b00; f = 2'b00; lg = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      if (reset) begin
        pipe_m[ch] = 2'b00; db_m[ch] = 1'b0; run_m[ch] = 0;
        cnt_m[ch] = 4'd0; quiet_m[ch] = 0; fired_m[ch] = 1'b0;
      end else begin
        s          = pipe_m[ch][1];
        pipe_m[ch] = {pipe_m[ch][0], btn_raw[ch]};
        prev_run   = run_m[ch];
        if (s != db_m[ch]) run_m[ch]++;
        else               run_m[ch] = 0;
        if (run_m[ch] == DEB) begin
          db_m[ch]  = s;
          run_m[ch] = 0;
          r[ch]     = s;
          f[ch]     = ~s;
        end
        if (r[ch])             cnt_m[ch] = press_clr[ch] ? 4'd1 : cnt_m[ch] + 4'd1;
        else if (press_clr[ch]) cnt_m[ch] = 4'd0;
        if (r[ch]) begin
          quiet_m[ch] = 0;
          fired_m[ch] = 1'b0;
        end else if (db_m[ch] && s && prev_run == 0) begin
          if (!fired_m[ch]) begin
            quiet_m[ch]++;
            if (quiet_m[ch] == LONG) begin
              lg[ch]      = 1'b1;
              fired_m[ch] = 1'b1;
            end
          end
        end else begin
          quiet_m[ch] = 0;
        end
      end
    end
    exp_q.push_back({lg, cnt_m[1], cnt_m[0], f, r, db_m[1], db_m[0]});
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("model_db",    32'(btn_db),      32'(e[1:0]));
      check("model_rise",  32'(btn_rise),    32'(e[3:2]));
      check("model_fall",  32'(btn_fall),    32'(e[5:4]));
      check("model_count", 32'(press_count), 32'(e[13:6]));
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
      check("model_long",  32'(btn_long),    32'(e[15:14]));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press0();
    btn_raw[0] = 1'b1;
    repeat (8) tick();
    btn_raw[0] = 1'b0;
    repeat (8) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lvl[2];
    int rem[2];
    reset     = 1'b1;
    btn_raw   = 2'b00;
    press_clr = 2'b00;
    repeat (2) tick();
    check("reset_db",    32'(btn_db),      32'd0);
    check("reset_rise",  32'(btn_rise),    32'd0);
    check("reset_count", 32'(press_count), 32'd0);
    reset = 1'b0;
    repeat (6) tick();

    // clean step on channel 0
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("step_db0",   32'(btn_db[0]),   32'(k >= 5));
      check("step_rise0", 32'(btn_rise[0]), 32'(k == 5));
      check("step_db1",   32'(btn_db[1]),   32'd0);
    end
    check("step_count0", 32'(press_count[3:0]), 32'd1);
    btn_raw[0] = 1'b0;
    repeat (10) tick();

    // bouncing channel 1
    for (int b = 0; b < 4; b++) begin
      btn_raw[1] = (b % 2 == 0);
      repeat (2) begin
        tick();
        check("bounce_rise1", 32'(btn_rise[1]), 32'd0);
      end
    end
    btn_raw[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bounce_final_rise1", 32'(btn_rise[1]), 32'(k == 5));
    end
    btn_raw[1] = 1'b0;
    repeat (10) tick();

    // counter wrap and clear-with-rise on channel 0
    press_clr[0] = 1'b1;
    tick();
    press_clr[0] = 1'b0;
    check("clr_count0", 32'(press_count[3:0]), 32'd0);
    repeat (15) press0();
    check("wrap_count0_15", 32'(press_count[3:0]), 32'd15);
    press0();
    check("wrap_count0_0", 32'(press_count[3:0]), 32'd0);
    btn_raw[0] = 1'b1;
    repeat (5) tick();
    press_clr[0] = 1'b1;
    tick();
    press_clr[0] = 1'b0;
    check("clr_rise_rise0",  32'(btn_rise[0]),       32'd1);
    check("clr_rise_count0", 32'(press_count[3:0]), 32'd1);
    repeat (3) tick();

    // reset while channel 0 sits in CHECK_LOW with db still high
    btn_raw[0] = 1'b0;
    repeat (4) tick();
    check("pre_reset_db0", 32'(btn_db[0]), 32'd1);
    reset      = 1'b1;
    btn_raw[0] = 1'b1;
    tick();
    check("mid_reset_db0",    32'(btn_db[0]),   32'd0);
    check("mid_reset_fall0",  32'(btn_fall[0]), 32'd0);
    check("mid_reset_count",  32'(press_count), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("post_reset_rise0", 32'(btn_rise[0]), 32'(k == 5));
    end
    btn_raw[0] = 1'b0;
    repeat (10) tick();

    // simultaneous steps on both channels
    btn_raw = 2'b11;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("simul_rise", 32'(btn_rise), (k == 5) ? 32'd3 : 32'd0);
    end
    check("simul_count", 32'(press_count), 32'h12);

    // clear alone on channel 1
    press_clr = 2'b10;
    tick();
    press_clr = 2'b00;
    check("clr_alone_count", 32'(press_count), 32'h02);
    btn_raw = 2'b00;
    repeat (10) tick();

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    // long press held, then a short press that must not fire
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 31; k++) begin
      tick();
      check("long_held", 32'(btn_long[0]), 32'(k == 15));
    end
    btn_raw[0] = 1'b0;
    repeat (12) tick();
    btn_raw[0] = 1'b1;
    repeat (8) tick();
    btn_raw[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("long_short", 32'(btn_long[0]), 32'd0);
    end
`endif

    // randomized phase: bouncy levels with random hold lengths, sparse clears
    // and occasional resets
    lvl[0] = 0; lvl[1] = 0; rem[0] = 1; rem[1] = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        rem[ch]--;
        if (rem[ch] <= 0) begin
          lvl[ch] = 1 - lvl[ch];
          rem[ch] = int'($urandom_range(1, 12));
        end
        btn_raw[ch]   = (lvl[ch] != 0);
        press_clr[ch] = ($urandom_range(0, 199) == 0);
      end
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset     = 1'b0;
    press_clr = 2'b00;
    btn_raw   = 2'b00;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream conditioning stage for the Wishbone button/LED peripheral.
- Takes asynchronous raw pad inputs and synchronises each one, then debounces it.
- Drives the clean level into the peripheral's `buttons` input.
- Also produces single-cycle press/release pulses and a per-button press counter for firmware-visible event counting.

Parameters:
- N_BUTTONS, 2, number of independent button channels.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a level change; legal range 2..65535.
- CNT_W, 8, width of each press counter.
- LONG_CYCLES, 1000000, cycles held high before the long-press pulse (only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn_raw  in  N_BUTTONS  asynchronous raw button pads, active-high.
- btn_db  out  N_BUTTONS  debounced level; feeds the peripheral's `buttons` port.
- btn_rise  out  N_BUTTONS  1-cycle pulse when btn_db goes 0->1.
- btn_fall  out  N_BUTTONS  1-cycle pulse when btn_db goes 1->0.
- press_clr  in  N_BUTTONS  synchronous clear of the matching press counter.
- press_count  out  N_BUTTONS*CNT_W  flattened counters; channel i occupies bits [i*CNT_W +: CNT_W].
- btn_long  out  N_BUTTONS  long-press pulse; present only when LONG_PRESS_EN is defined.

Behaviour:
- Reset: clk rising edge with reset high. Sync flops, btn_db, btn_rise, btn_fall, press_count, btn_long and all counters clear to 0; every FSM goes to STABLE_LOW. Reset wins over every other input in that cycle.
- Synchroniser: 2-FF per channel; s = second flop. Synchroniser is included in latency.
- Per-channel FSM, 4 states:
  - STABLE_LOW: when s==1, go to CHECK_HIGH and set cnt=1.
  - CHECK_HIGH:
    - s==0: back to STABLE_LOW, cnt=0 (glitch rejected, no pulse).
    - s==1 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_HIGH, btn_db<=1, btn_rise<=1 for one cycle.
    - otherwise: cnt++.
  - STABLE_HIGH: when s==0, go to CHECK_LOW and set cnt=1.
  - CHECK_LOW: mirror of CHECK_HIGH. Accept ends in STABLE_LOW with btn_db<=0 and btn_fall<=1.
- Latency: a clean raw step (setup met before edge 0) appears on btn_db at edge DEBOUNCE_CYCLES+1. The rise/fall pulse is asserted in the same cycle as btn_db changes.
- Glitch rejection: any raw pulse shorter than DEBOUNCE_CYCLES-1 synchronised cycles never changes btn_db. A bouncing input restarts the count on every reversal.
- btn_rise and btn_fall are registered, mutually exclusive per channel, and never asserted back-to-back closer than DEBOUNCE_CYCLES cycles.
- press_count[i]:
  - Increments by 1 in the cycle btn_rise[i] is asserted.
  - Wraps from 2^CNT_W-1 to 0.
  - press_clr[i] alone sets it to 0.
  - press_clr[i] in the same cycle as btn_rise[i] sets it to 1 (the new event is not lost).
- Channels are fully independent; simultaneous events on different channels are all honoured.
- cnt width: $clog2(DEBOUNCE_CYCLES)+1; cnt never exceeds DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_LONG_PRESS_EN.
- Defined:
  - Per-channel hold counter, width $clog2(LONG_CYCLES)+1.
  - Clears on btn_rise and counts while in STABLE_HIGH.
  - btn_long[i] pulses for 1 cycle when the hold count reaches LONG_CYCLES-1.
  - At most one long pulse per press; the counter then saturates with no further pulses until the next rise.
  - Leaving STABLE_HIGH clears the hold counter.
- Undefined: the btn_long port and the hold counters are absent. All other behaviour is identical.

Decomposition:
- Shared package button_pkg:
  - FSM state encoding: STABLE_LOW=2'd0, CHECK_HIGH=2'd1, STABLE_HIGH=2'd2, CHECK_LOW=2'd3.
  - Default DEBOUNCE_CYCLES and CNT_W constants.
- Sub-module debounce_chan: one channel containing the synchroniser, FSM, cnt, press counter and optional long-press logic.
- Top level: a generate loop of N_BUTTONS instances plus port flattening.

Test Plan (bench uses DEBOUNCE_CYCLES=4, CNT_W=4, LONG_CYCLES=10):
- Clean step: btn_raw[0] 0->1 before edge 0, held high -> btn_db[0]=1 and btn_rise[0]=1 at edge 5 only; press_count[0]=1. Channel 1 stays 0.
- Bounce: btn_raw[1] toggles 1,0,1,0 every 2 cycles, then held 1 -> no rise during the bounce; exactly one btn_rise[1], at edge 5 after the last 0->1 step.
- Wrap and clear: 16 clean presses on ch0 -> press_count[0] goes 15->0. Then press_clr[0] asserted in the rise cycle of the next press -> count=1.
- Reset mid-operation: reset asserted while ch0 is in CHECK_LOW with btn_db=1 -> next cycle btn_db=0, count=0, no fall pulse. Raw held 1 after reset -> rise DEBOUNCE_CYCLES+1 cycles after reset deasserts.
- Simultaneous: both channels step high on the same cycle -> both rise pulses on the same edge; both counters increment.
- LONG_PRESS_EN: hold ch0 high for 30 cycles -> btn_long[0] pulses once, 10 cycles after btn_rise[0]; no pulse if released after 8 cycles.
